// File: rtl/wb_regfile.sv
// Write-back mux, 2^ADDR_W-entry register file (x0 hardwired to 0) and commit counter; writes land on posedge Clk.
// Optional WB_REGFILE_BYPASS_EN makes both read ports write-through for a same-cycle pending commit.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        WB_DBDataSrc,
  input  logic              WB_RegWre,
  input  logic [DATA_W-1:0] WB_PCadd4,
  input  logic [DATA_W-1:0] WB_DataFromMemory,
  input  logic [DATA_W-1:0] WB_DataFromALU,
  input  logic [ADDR_W-1:0] WB_WriteReg,
  input  logic [ADDR_W-1:0] ID_ReadReg1,
  input  logic [ADDR_W-1:0] ID_ReadReg2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [31:0]       WB_RetireCount
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [31:0]       retire_q, retire_d;
  logic              commit;

  always_comb begin
    WB_WriteData = WB_DataFromALU;
    case (WB_DBDataSrc)
      2'd1:    WB_WriteData = WB_DataFromMemory;
      2'd2:    WB_WriteData = WB_PCadd4;
      default: WB_WriteData = WB_DataFromALU;
    endcase
  end

  // Reset priority is applied in the register process, so commit excludes it here.
  assign commit = WB_RegWre && (WB_WriteReg != '0);

  always_comb begin
    retire_d = retire_q;
    if (commit) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      retire_q <= '0;
    end else begin
      if (commit) regs_q[WB_WriteReg] <= WB_WriteData;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    ID_ReadData1 = (ID_ReadReg1 == '0) ? '0 : regs_q[ID_ReadReg1];
    ID_ReadData2 = (ID_ReadReg2 == '0) ? '0 : regs_q[ID_ReadReg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (WB_WriteReg == ID_ReadReg1)) ID_ReadData1 = WB_WriteData;
    if (commit && (WB_WriteReg == ID_ReadReg2)) ID_ReadData2 = WB_WriteData;
`else
`endif
  end

  assign WB_RetireCount = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values queued when stimulus is driven, popped at each check.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [1:0]        WB_DBDataSrc;
  logic              WB_RegWre;
  logic [DATA_W-1:0] WB_PCadd4, WB_DataFromMemory, WB_DataFromALU;
  logic [ADDR_W-1:0] WB_WriteReg, ID_ReadReg1, ID_ReadReg2;
  logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, WB_WriteData;
  logic [31:0]       WB_RetireCount;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mux_exp [4];
  logic [31:0] byp_old;

  always #5 Clk = ~Clk;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .WB_DBDataSrc(WB_DBDataSrc), .WB_RegWre(WB_RegWre),
    .WB_PCadd4(WB_PCadd4), .WB_DataFromMemory(WB_DataFromMemory),
    .WB_DataFromALU(WB_DataFromALU), .WB_WriteReg(WB_WriteReg),
    .ID_ReadReg1(ID_ReadReg1), .ID_ReadReg2(ID_ReadReg2),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .WB_WriteData(WB_WriteData), .WB_RetireCount(WB_RetireCount)
  );

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mux_exp[0] = 32'h11; mux_exp[1] = 32'h22; mux_exp[2] = 32'h33; mux_exp[3] = 32'h11;
    Reset = 1'b1; WB_DBDataSrc = 2'd0; WB_RegWre = 1'b0;
    WB_PCadd4 = '0; WB_DataFromMemory = '0; WB_DataFromALU = '0;
    WB_WriteReg = '0; ID_ReadReg1 = '0; ID_ReadReg2 = '0;
    repeat (2) @(posedge Clk);
    #1;
    push(32'd0); check("rst_count", WB_RetireCount);
    ID_ReadReg1 = 5'd1; ID_ReadReg2 = 5'd31; #1;
    push(32'd0); check("rst_rd1", ID_ReadData1);
    push(32'd0); check("rst_rd2", ID_ReadData2);

    // Preload regs 1..31 with non-zero values
    @(negedge Clk);
    Reset = 1'b0; WB_RegWre = 1'b1; WB_DBDataSrc = 2'd0;
    for (int i = 1; i < 32; i++) begin
      WB_WriteReg = 5'(i);
      WB_DataFromALU = 32'h01010101 * i;
      @(negedge Clk);
    end
    WB_RegWre = 1'b0;
    ID_ReadReg1 = 5'd1; ID_ReadReg2 = 5'd31; #1;
    push(32'h01010101); check("pre_rd1", ID_ReadData1);
    push(32'h1F1F1F1F); check("pre_rd2", ID_ReadData2);
    push(32'd31);       check("pre_count", WB_RetireCount);

    // Single reset edge clears everything
    Reset = 1'b1;
    @(posedge Clk); #1;
    push(32'd0); check("reset_count", WB_RetireCount);
    for (int i = 0; i < 16; i++) begin
      ID_ReadReg1 = 5'(i); ID_ReadReg2 = 5'(i + 16); #1;
      push(32'd0); check("reset_rd1", ID_ReadData1);
      push(32'd0); check("reset_rd2", ID_ReadData2);
    end
    @(negedge Clk);
    Reset = 1'b0;

    // Write-back source sweep into reg 5
    WB_RegWre = 1'b1; WB_WriteReg = 5'd5;
    WB_DataFromALU = 32'h11; WB_DataFromMemory = 32'h22; WB_PCadd4 = 32'h33;
    ID_ReadReg1 = 5'd5;
    for (int s = 0; s < 4; s++) begin
      WB_DBDataSrc = 2'(s); #1;
      push(mux_exp[s]); check("mux_wbdata", WB_WriteData);
      @(posedge Clk); #1;
      push(mux_exp[s]); check("mux_rd", ID_ReadData1);
      @(negedge Clk);
    end
    push(32'd4); check("mux_count", WB_RetireCount);

    // Write to reg 0 is discarded and not counted
    WB_WriteReg = 5'd0; WB_DBDataSrc = 2'd0; WB_DataFromALU = 32'hDEADBEEF;
    ID_ReadReg1 = 5'd0; ID_ReadReg2 = 5'd0;
    @(posedge Clk); #1;
    push(32'd0); check("zero_rd1", ID_ReadData1);
    push(32'd0); check("zero_rd2", ID_ReadData2);
    push(32'd4); check("zero_count", WB_RetireCount);

    // Read-during-write on reg 7, both ports
    @(negedge Clk);
    WB_WriteReg = 5'd7; WB_DataFromALU = 32'h1234;
    @(negedge Clk);
    WB_DataFromALU = 32'hCAFE; ID_ReadReg1 = 5'd7; ID_ReadReg2 = 5'd7; #1;
`ifdef WB_REGFILE_BYPASS_EN
    byp_old = 32'hCAFE;
`else
    byp_old = 32'h1234;
`endif
    push(byp_old); check("byp_pre_rd1", ID_ReadData1);
    push(byp_old); check("byp_pre_rd2", ID_ReadData2);
    @(posedge Clk); #1;
    push(32'hCAFE); check("byp_post_rd1", ID_ReadData1);
    push(32'hCAFE); check("byp_post_rd2", ID_ReadData2);
    push(32'd6);    check("byp_count", WB_RetireCount);
    @(negedge Clk);
    WB_RegWre = 1'b0; WB_DataFromALU = 32'hBEEF; #1;
    push(32'hCAFE); check("nowre_pre_rd1", ID_ReadData1);
    @(posedge Clk); #1;
    push(32'hCAFE); check("nowre_post_rd1", ID_ReadData1);
    push(32'd6);    check("nowre_count", WB_RetireCount);

    // Counter wrap: load 0xFFFFFFFF through the next-state, then one commit
    @(negedge Clk);
    force dut.retire_d = 32'hFFFFFFFF;
    @(negedge Clk);
    release dut.retire_d;
    #1;
    push(32'hFFFFFFFF); check("wrap_pre_count", WB_RetireCount);
    WB_RegWre = 1'b1; WB_WriteReg = 5'd9; WB_DataFromALU = 32'h77; WB_DBDataSrc = 2'd0;
    @(posedge Clk); #1;
    push(32'd0); check("wrap_count", WB_RetireCount);
    ID_ReadReg1 = 5'd9; #1;
    push(32'h77); check("wrap_rd", ID_ReadData1);

    // Reset wins over a simultaneous write
    @(negedge Clk);
    Reset = 1'b1; WB_WriteReg = 5'd3; WB_DataFromALU = 32'h55;
    ID_ReadReg1 = 5'd3; ID_ReadReg2 = 5'd9;
    @(posedge Clk); #1;
    push(32'd0); check("rstpri_rd3", ID_ReadData1);
    push(32'd0); check("rstpri_rd9", ID_ReadData2);
    push(32'd0); check("rstpri_count", WB_RetireCount);
    @(negedge Clk);
    Reset = 1'b0; WB_RegWre = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
